// File: rtl/sub_bytes_iter.sv
// sub_bytes_iter: iterative AES SubBytes over a 128-bit state.
// NUM_SBOX lanes substitute NUM_SBOX bytes per cycle, MSB byte first, so a
// transform occupies 16/NUM_SBOX BUSY cycles.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_data captured on accept
//   in_data[127:0]       state, byte k = in_data[127-8k -: 8]
//   out_valid/out_ready  output handshake; out_data valid while out_valid
//   out_data[127:0]      working register (SubBytes result in DONE)
//   busy                 transform in progress
module sub_bytes_iter #(
    parameter int unsigned NUM_SBOX = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int unsigned NBYTES = 16;
    localparam int unsigned IDX_W  = 4;
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(NUM_SBOX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - NUM_SBOX);
    localparam logic [IDX_W-1:0] BYTE_TOP = IDX_W'(NBYTES - 1);

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
        $fatal(1, "sub_bytes_iter: NUM_SBOX must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [NBYTES-1:0][7:0]      work_q, work_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_SBOX-1:0][7:0]    lane_in;
    logic [NUM_SBOX-1:0][7:0]    lane_out;

    // Lane j works on byte idx+j; byte k lives in packed element 15-k.
    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        logic [IDX_W-1:0] pos;
        assign pos        = BYTE_TOP - (idx_q + IDX_W'(j));
        assign lane_in[j] = work_q[pos];
        sub_bytes_iter_sbox u_sbox (
            .a (lane_in[j]),
            .c (lane_out[j])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the last BUSY step is the one whose write covers byte 15
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)          state_d = S_BUSY;
            S_BUSY:  if (idx_q == IDX_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready)         state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Output decode of the registered state
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_BUSY);
        out_data  = work_q;
    end

    // Working register and byte counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            idx_q  <= '0;
        end else begin
            work_q <= work_d;
            idx_q  <= idx_d;
        end
    end

    // Capture on accept, substitute in place while BUSY; idx wraps to 0 after byte 15
    always_comb begin
        work_d = work_q;
        idx_d  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    idx_d  = '0;
                end
            end
            S_BUSY: begin
                for (int j = 0; j < NUM_SBOX; j++) begin
                    work_d[BYTE_TOP - (idx_q + IDX_W'(j))] = lane_out[j];
                end
                idx_d = idx_q + IDX_STEP;
            end
            default: ;
        endcase
    end

endmodule

// AES S-box: multiplicative inverse in GF(2^8) as a^254, then the affine map.
module sub_bytes_iter_sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    logic [7:0] x2, x3, x12, x15, x240, inv;

    // Addition chain for a^254; maps 0 to 0 as AES requires
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(x3, x3);
        x12  = gf_mul(x12, x12);
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        c    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: doc/sub_bytes_iter.md
SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 Parameter: NUM_SBOX, default 1, number of parallel sbox lanes; legal values 1, 2, 4 only, others SHALL fail elaboration.
REQ-002 Ports, one clock; reset is asynchronous and active-high:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data holds a 128-bit AES state to transform.
- in_ready  output  1  block can accept a state.
- in_data  input  128  state; byte k = in_data[127-8k -: 8], k=0..15.
- out_valid  output  1  out_data holds the completed SubBytes result.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  128  SubBytes(in_data), same byte ordering.
- busy  output  1  high while a transform is in progress (state BUSY).

Function
REQ-003 The block SHALL instantiate exactly NUM_SBOX copies of the combinational sbox (a[7:0] -> c[7:0]) and no other substitution logic.
REQ-004 FSM states SHALL be IDLE, BUSY, DONE; encoding is free.
REQ-005 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE); busy SHALL equal (state==BUSY); all three are combinational decodes of the registered state.
REQ-006 IDLE: on in_valid && in_ready at a rising edge, the block SHALL capture in_data into a 128-bit working register, clear byte counter idx to 0, and go to BUSY.
REQ-007 BUSY: each cycle, lane j (j=0..NUM_SBOX-1) SHALL feed byte idx+j of the working register to sbox j and write its output back to the same byte position at the edge.
- idx then advances by NUM_SBOX.
REQ-008 Bytes SHALL be processed in ascending k order (MSB byte first). idx is a 4-bit counter.
- When the write covering byte 15 occurs, the state SHALL go to DONE; idx wraps to 0 and is unused there.
REQ-009 BUSY SHALL last exactly 16/NUM_SBOX cycles.
- out_valid SHALL rise on the edge after the last write: accept edge at cycle 0, out_valid high from cycle 16/NUM_SBOX.
REQ-010 DONE: out_data SHALL equal the working register and stay stable while out_valid && !out_ready.
REQ-011 DONE with out_ready high at an edge SHALL return to IDLE.
- A new input SHALL NOT be accepted in that same cycle, because in_ready is low in DONE.
- Minimum issue interval is therefore 16/NUM_SBOX + 2 cycles.
REQ-012 in_valid and in_data SHALL be ignored outside IDLE; in_data is sampled only at the accept edge, so later changes have no effect.
REQ-013 out_ready SHALL be ignored outside DONE.
REQ-014 out_data SHALL reflect the working register at all times.
- The value is partially substituted during BUSY and is valid only while out_valid is high.
REQ-015 No combinational path SHALL exist from in_valid or out_ready to any output.

Reset
REQ-016 While rst is high, the following SHALL hold asynchronously: state=IDLE, idx=0, working register=0.
- Resulting outputs: in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-017 Reset asserted in BUSY or DONE SHALL abort the transform without producing out_valid.
- The first accept after reset release SHALL behave as from a fresh IDLE.
REQ-018 Deassertion of rst is synchronous to clk in the surrounding system; the block adds no synchronizer.

Verification
REQ-019 Reset values: assert rst mid-cycle with no clk edge -> immediately in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-020 FIPS-197 vector, NUM_SBOX=1: accept in_data=00112233445566778899aabbccddeeff with out_ready held high.
- out_valid SHALL be high exactly at cycle 16 with out_data=638293c31bfc33f5c4eeacea4bc12816.
- in_ready SHALL return at cycle 17.
REQ-021 All-zero state, NUM_SBOX=4: out_data=6363...63 (16 bytes), with out_valid at cycle 4 after the accept edge.
REQ-022 Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle in_valid and in_data meanwhile.
- out_data and out_valid SHALL stay constant and in_ready SHALL stay 0.
- out_ready=1 -> IDLE on the next edge.
REQ-023 Abort: pulse rst at BUSY cycle 7, then accept in_data=ff..ff.
- The only completion SHALL be out_data=1616...16, with normal latency.
REQ-024 Exhaustive lane check: stream 16 states covering byte values 00..ff across all positions, with random out_ready stalls.
- Every result SHALL match a reference SubBytes model for NUM_SBOX=1, 2 and 4.
